// File: rtl/ereset_seq.sv
// Reset sequencer feeding the elink per-domain reset synchronizers: merges POR, enable,
// software reset and PLL lock into one minimum-width reset plus a settled-ready flag.
module ereset_seq #(
    parameter int HOLD_CYCLES   = 64,
    parameter int RELEASE_DELAY = 16,
    parameter int CW            = 8
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       elink_en,
    input  logic       soft_reset,
    input  logic       pll_locked,
    output logic       elink_reset,
    output logic       elink_ready,
    output logic       lock_lost,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        ASSERT    = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD      = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_DELAY - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lock_meta, lock_s;
    logic          lost_set;

    // Counter is zeroed on every state change so it never carries between phases.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lost_set  = 1'b0;
        if (state != ASSERT && (soft_reset || !elink_en)) begin
            state_nxt = ASSERT;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ASSERT: begin
                    cnt_nxt = '0;
                    if (elink_en && !soft_reset)
                        state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == HOLD_LAST) begin
                        state_nxt = RELEASE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state_nxt = ASSERT;
                        cnt_nxt   = '0;
                        lost_set  = 1'b1;
                    end else if (cnt == REL_LAST) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RUN: begin
                    cnt_nxt = '0;
                    if (!lock_s) begin
                        state_nxt = ASSERT;
                        lost_set  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ASSERT;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as the state register.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            lock_meta   <= 1'b0;
            lock_s      <= 1'b0;
            state       <= ASSERT;
            cnt         <= '0;
            elink_reset <= 1'b1;
            elink_ready <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            lock_meta   <= pll_locked;
            lock_s      <= lock_meta;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            elink_reset <= (state_nxt == ASSERT) || (state_nxt == WAIT_LOCK) || (state_nxt == HOLD);
            elink_ready <= (state_nxt == RUN);
            lock_lost   <= !soft_reset && (lock_lost || lost_set);
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_ereset_seq.sv
// Scoreboard bench for ereset_seq: expected output changes (value and edge number) are
// queued as stimulus is applied and matched against every observed change.
module tb_ereset_seq;

    localparam int HOLD = 64;
    localparam int REL  = 16;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       elink_en;
    logic       soft_reset;
    logic       pll_locked;
    logic       elink_reset;
    logic       elink_ready;
    logic       lock_lost;
    logic [2:0] seq_state;

    always #5 sys_clk = ~sys_clk;

    ereset_seq #(
        .HOLD_CYCLES  (HOLD),
        .RELEASE_DELAY(REL),
        .CW           (8)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .elink_en   (elink_en),
        .soft_reset (soft_reset),
        .pll_locked (pll_locked),
        .elink_reset(elink_reset),
        .elink_ready(elink_ready),
        .lock_lost  (lock_lost),
        .seq_state  (seq_state)
    );

    typedef struct {
        int         cyc;
        logic [5:0] val;
        string      tag;
    } ev_t;

    ev_t        q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    logic [5:0] prev;

    function automatic logic [5:0] snap();
        return {seq_state, elink_reset, elink_ready, lock_lost};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input string tag, input int c, input logic [2:0] st,
                        input logic r, input logic rd, input logic l);
        ev_t e;
        e.cyc = c;
        e.val = {st, r, rd, l};
        e.tag = tag;
        q.push_back(e);
    endtask

    // HOLD entry at h, then RELEASE and RUN at the nominal spacing.
    task automatic push_seq(input string tag, input int h, input logic l);
        push({tag, "_hold"}, h, 3'd2, 1'b1, 1'b0, l);
        push({tag, "_release"}, h + HOLD, 3'd3, 1'b0, 1'b0, l);
        push({tag, "_run"}, h + HOLD + REL, 3'd4, 1'b0, 1'b1, l);
    endtask

    task automatic tick();
        ev_t        e;
        logic [5:0] now;
        @(posedge sys_clk);
        #1;
        cyc++;
        now = snap();
        if (now !== prev) begin
            if (q.size() == 0) begin
                chk("unexpected_change", {26'd0, now}, {26'd0, prev});
            end else begin
                e = q.pop_front();
                chk({e.tag, "_val"}, {26'd0, now}, {26'd0, e.val});
                chk({e.tag, "_cyc"}, cyc, e.cyc);
            end
            prev = now;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_pending"}, q.size(), 0);
        q.delete();
    endtask

    initial begin
        int c;
        int h;

        reset      = 1'b1;
        elink_en   = 1'b1;
        soft_reset = 1'b0;
        pll_locked = 1'b1;
        #1;
        prev = snap();
        chk("por_state", seq_state, 0);
        chk("por_reset", elink_reset, 1);
        chk("por_ready", elink_ready, 0);
        chk("por_lost", lock_lost, 0);

        // 1: nominal sequence out of POR
        repeat (5) tick();
        reset = 1'b0;
        c = cyc;
        push("t1_wait", c + 1, 3'd1, 1'b1, 1'b0, 1'b0);
        push_seq("t1", c + 3, 1'b0);
        drain("t1", 200);
        repeat (5) tick();

        // 2: enable low for 1000 cycles; any output movement is flagged by the monitor
        elink_en = 1'b0;
        push("t2_assert", cyc + 1, 3'd0, 1'b1, 1'b0, 1'b0);
        repeat (1000) tick();
        chk("t2_pending", q.size(), 0);
        chk("t2_state", seq_state, 0);
        chk("t2_reset", elink_reset, 1);
        chk("t2_ready", elink_ready, 0);

        // 3: lock drop at HOLD count 30, back 10 cycles later
        elink_en = 1'b1;
        c = cyc;
        h = c + 2;
        push("t3_wait_a", c + 1, 3'd1, 1'b1, 1'b0, 1'b0);
        push("t3_hold_a", h, 3'd2, 1'b1, 1'b0, 1'b0);
        while (cyc < h + 30) tick();
        pll_locked = 1'b0;
        push("t3_wait_b", h + 33, 3'd1, 1'b1, 1'b0, 1'b0);
        while (cyc < h + 40) tick();
        pll_locked = 1'b1;
        push_seq("t3", h + 43, 1'b0);
        drain("t3", 300);
        chk("t3_lost", lock_lost, 0);
        repeat (5) tick();

        // 4: single soft_reset pulse in RUN
        soft_reset = 1'b1;
        c = cyc;
        push("t4_assert", c + 1, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        soft_reset = 1'b0;
        push("t4_wait", c + 2, 3'd1, 1'b1, 1'b0, 1'b0);
        push_seq("t4", c + 3, 1'b0);
        drain("t4", 300);
        repeat (5) tick();

        // 5: lock loss in RUN sets sticky lock_lost; soft_reset clears it
        pll_locked = 1'b0;
        c = cyc;
        push("t5_assert", c + 3, 3'd0, 1'b1, 1'b0, 1'b1);
        push("t5_wait", c + 4, 3'd1, 1'b1, 1'b0, 1'b1);
        while (cyc < c + 10) tick();
        pll_locked = 1'b1;
        push_seq("t5", c + 13, 1'b1);
        drain("t5", 300);
        repeat (20) tick();
        chk("t5_sticky", lock_lost, 1);
        soft_reset = 1'b1;
        c = cyc;
        push("t5_clear", c + 1, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        soft_reset = 1'b0;
        push("t5_rewait", c + 2, 3'd1, 1'b1, 1'b0, 1'b0);
        push_seq("t5b", c + 3, 1'b0);

        // 6: asynchronous reset mid-HOLD, then mid-RUN, between clock edges
        while (cyc < c + 23) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t6h_state", seq_state, 0);
        chk("t6h_reset", elink_reset, 1);
        chk("t6h_ready", elink_ready, 0);
        q.delete();
        prev = snap();
        repeat (2) tick();
        reset = 1'b0;
        c = cyc;
        push("t6_wait", c + 1, 3'd1, 1'b1, 1'b0, 1'b0);
        push_seq("t6", c + 3, 1'b0);
        drain("t6", 200);
        repeat (10) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t6r_state", seq_state, 0);
        chk("t6r_reset", elink_reset, 1);
        chk("t6r_ready", elink_ready, 0);
        chk("t6r_lost", lock_lost, 0);
        prev = snap();
        tick();
        reset = 1'b0;
        c = cyc;
        push("t6b_wait", c + 1, 3'd1, 1'b1, 1'b0, 1'b0);
        push_seq("t6b", c + 3, 1'b0);
        drain("t6b", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
